pipe_skid_stage: RTL and testbench

Parametrised, elastic replacement for the fixed inter-stage flop banks (fetch/decode, decode/execute, execute/memory, memory/writeback) in the pipelined processor.
- Carries an arbitrary-width payload with a valid/ready handshake instead of a bare enable.
- Provides a 2-entry skid buffer so back-pressure never drops a word.
- Keeps the existing freeze and local_clr semantics: hold and flush-to-bubble.
- Sits between any two pipeline stages. The hazard unit drives freeze and local_clr.

---
 rtl/pipe_skid_stage.sv | 158 +++++++++++++++
 tb/tb_pipe_skid_stage.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
//============================================================================
// Module   : pipe_skid_stage
// Purpose  : Elastic inter-stage pipeline register with a valid/ready
//            handshake and a 2-entry skid buffer. It keeps the hazard-unit
//            controls: freeze holds the stage, local_clr flushes it to a
//            bubble.
// Options  : Define PIPE_SKID_BUBBLE_CNT_EN to add the bubble_cnt output,
//            a saturating count of genuine bubble cycles.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module pipe_skid_stage #(
    parameter int                 DATA_W    = 16,
    parameter logic [DATA_W-1:0]  NOP_VALUE = DATA_W'(16'h0800)
) (
    input  logic                  clk,
    input  logic                  rst_n,

    // Upstream side
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,

    // Downstream side
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,

    // Hazard-unit controls
    input  logic                  freeze,
    input  logic                  local_clr,

    // Status
    output logic [1:0]            occupancy
`ifdef PIPE_SKID_BUBBLE_CNT_EN
    ,
    output logic [15:0]           bubble_cnt
`endif
);

    //------------------------------------------------------------------------
    // State encoding: number of words currently held
    //------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t                r_state;
    logic [DATA_W-1:0]     r_main;   // older word, drives out_data
    logic [DATA_W-1:0]     r_skid;   // younger word, only valid in ST_TWO

    logic                  w_accept;
    logic                  w_emit;

    //------------------------------------------------------------------------
    // Handshake. local_clr is deliberately not folded in here: the upstream
    // stage is flushed in the same cycle, so any word it offers is simply
    // discarded by the register update below.
    //------------------------------------------------------------------------
    assign in_ready  = (r_state != ST_TWO)   & ~freeze;
    assign out_valid = (r_state != ST_EMPTY) & ~freeze;
    assign w_accept  = in_valid  & in_ready;
    assign w_emit    = out_valid & out_ready;

    // Present a bubble when empty; freeze leaves the payload visible.
    always_comb begin
        out_data = r_main;
        if (r_state == ST_EMPTY) begin
            out_data = NOP_VALUE;
        end
    end

    // Occupancy mirrors the state encoding as a plain count.
    always_comb begin
        occupancy = 2'd0;
        case (r_state)
            ST_EMPTY: occupancy = 2'd0;
            ST_ONE:   occupancy = 2'd1;
            ST_TWO:   occupancy = 2'd2;
            default:  occupancy = 2'd0;
        endcase
    end

    //------------------------------------------------------------------------
    // Storage and FSM: reset > flush > freeze > normal handshake.
    // main always holds the older word so output order is strictly FIFO.
    //------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_main  <= NOP_VALUE;
            r_skid  <= NOP_VALUE;
        end else if (local_clr) begin
            r_state <= ST_EMPTY;
            r_main  <= NOP_VALUE;
            r_skid  <= NOP_VALUE;
        end else if (freeze) begin
            r_state <= r_state;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_state <= ST_ONE;
                        r_main  <= in_data;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_emit) begin
                        r_main  <= in_data;
                    end else if (w_accept) begin
                        // Downstream stalled: park the new word behind main.
                        r_state <= ST_TWO;
                        r_skid  <= in_data;
                    end else if (w_emit) begin
                        r_state <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only draining is possible.
                    if (w_emit) begin
                        r_state <= ST_ONE;
                        r_main  <= r_skid;
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                end
            endcase
        end
    end

`ifdef PIPE_SKID_BUBBLE_CNT_EN
    //------------------------------------------------------------------------
    // Bubble counter: cycles with no valid word that are not frozen stalls.
    // Only reset clears it so flushes stay visible in the statistic.
    //------------------------------------------------------------------------
    logic [15:0] r_bubble_cnt;
    logic        w_bubble;

    assign w_bubble   = ~out_valid & ~freeze;
    assign bubble_cnt = r_bubble_cnt;

    // Saturating increment on each genuine bubble cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= 16'd0;
        end else if (w_bubble && (r_bubble_cnt != 16'hFFFF)) begin
            r_bubble_cnt <= r_bubble_cnt + 16'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
//============================================================================
// Module   : tb_pipe_skid_stage
// Purpose  : Directed self-checking bench for pipe_skid_stage.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_pipe_skid_stage;

    localparam int DATA_W = 16;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              freeze;
    logic              local_clr;
    logic [1:0]        occupancy;
`ifdef PIPE_SKID_BUBBLE_CNT_EN
    logic [15:0]       bubble_cnt;
`endif

    int errors = 0;
    int checks = 0;

    pipe_skid_stage #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .freeze    (freeze),
        .local_clr (local_clr),
        .occupancy (occupancy)
`ifdef PIPE_SKID_BUBBLE_CNT_EN
        ,
        .bubble_cnt(bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        freeze    = 1'b0;
        local_clr = 1'b0;

        // ---------------- Reset state ----------------
        #1;
        check("rst_in_ready",  32'(in_ready),  32'h1);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data",  32'(out_data),  32'h0800);
        check("rst_occupancy", 32'(occupancy), 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // ---------------- Back-pressure ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'hA001;
        tick();
        check("bp_occ1",       32'(occupancy), 32'h1);
        check("bp_rdy1",       32'(in_ready),  32'h1);
        check("bp_vld1",       32'(out_valid), 32'h1);
        check("bp_data1",      32'(out_data),  32'hA001);
        in_data = 16'hA002;
        tick();
        check("bp_occ2",       32'(occupancy), 32'h2);
        check("bp_rdy2",       32'(in_ready),  32'h0);
        check("bp_data2",      32'(out_data),  32'hA001);
        in_data = 16'hA003;
        tick();
        check("bp_hold_occ",   32'(occupancy), 32'h2);
        check("bp_hold_data",  32'(out_data),  32'hA001);
        out_ready = 1'b1;
        #1;
        check("bp_out1_vld",   32'(out_valid), 32'h1);
        check("bp_out1",       32'(out_data),  32'hA001);
        tick();
        check("bp_out2",       32'(out_data),  32'hA002);
        check("bp_out2_occ",   32'(occupancy), 32'h1);
        check("bp_out2_rdy",   32'(in_ready),  32'h1);
        tick();
        check("bp_out3",       32'(out_data),  32'hA003);
        check("bp_out3_occ",   32'(occupancy), 32'h1);
        in_valid = 1'b0;
        tick();
        check("bp_drain_occ",  32'(occupancy), 32'h0);
        check("bp_drain_vld",  32'(out_valid), 32'h0);
        check("bp_drain_data", 32'(out_data),  32'h0800);

        // ---------------- Streaming ----------------
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_data = 16'(i);
            #1;
            check("st_rdy", 32'(in_ready), 32'h1);
            tick();
            check("st_data", 32'(out_data),  32'(i));
            check("st_occ",  32'(occupancy), 32'h1);
        end
        in_valid = 1'b0;
        tick();
        check("st_end_occ", 32'(occupancy), 32'h0);

        // ---------------- Freeze ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h1234;
        tick();
        check("fz_load", 32'(out_data), 32'h1234);
        freeze    = 1'b1;
        in_data   = 16'h5555;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("fz_vld",  32'(out_valid), 32'h0);
            check("fz_rdy",  32'(in_ready),  32'h0);
            check("fz_data", 32'(out_data),  32'h1234);
            check("fz_occ",  32'(occupancy), 32'h1);
            tick();
        end
        check("fz_after_occ", 32'(occupancy), 32'h1);
        freeze   = 1'b0;
        in_valid = 1'b0;
        #1;
        check("fz_rel_vld",  32'(out_valid), 32'h1);
        check("fz_rel_data", 32'(out_data),  32'h1234);
        tick();
        check("fz_rel_occ",  32'(occupancy), 32'h0);

        // ---------------- Flush ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'hC001;
        tick();
        in_data   = 16'hC002;
        tick();
        check("fl_full", 32'(occupancy), 32'h2);
        local_clr = 1'b1;
        freeze    = 1'b1;
        in_data   = 16'hBEEF;
        tick();
        local_clr = 1'b0;
        freeze    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("fl_occ",  32'(occupancy), 32'h0);
        check("fl_data", 32'(out_data),  32'h0800);
        check("fl_vld",  32'(out_valid), 32'h0);
        tick();
        check("fl_nobeef", 32'(out_data), 32'h0800);

        // ---------------- Async reset mid-transfer ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'hD001;
        tick();
        in_data   = 16'hD002;
        tick();
        check("ar_full", 32'(occupancy), 32'h2);
        rst_n = 1'b0;
        #1;
        check("ar_vld",  32'(out_valid), 32'h0);
        check("ar_data", 32'(out_data),  32'h0800);
        check("ar_rdy",  32'(in_ready),  32'h1);
        check("ar_occ",  32'(occupancy), 32'h0);
        in_valid = 1'b0;
        #1;
        rst_n = 1'b1;

`ifdef PIPE_SKID_BUBBLE_CNT_EN
        // ---------------- Bubble counter ----------------
        check("bc_zero", 32'(bubble_cnt), 32'h0);
        repeat (5) tick();
        freeze = 1'b1;
        repeat (2) tick();
        check("bc_five", 32'(bubble_cnt), 32'd5);
        freeze = 1'b0;
        repeat (70000) @(posedge clk);
        #2;
        check("bc_sat", 32'(bubble_cnt), 32'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
